// File: rtl/sensor_input_conditioner.sv
// Board-pin front end: synchronizes and debounces nine raw inputs, commits the
// three water probes as one atomic group, and turns the buttons into pulses.
module sensor_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_low_water,
  input  logic raw_mid_water,
  input  logic raw_high_water,
  input  logic raw_earth_humidity,
  input  logic raw_air_humidity,
  input  logic raw_low_temperature,
  input  logic raw_selector,
  input  logic raw_button_2,
  input  logic raw_button_3,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic selector,
  output logic pulse_2,
  output logic pulse_3,
  output logic sensor_change
);

  localparam int NUM_CHANNELS = 9;
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Channel order: [2:0] water low/mid/high, [6:3] earth/air/temp/selector,
  // [8:7] button 2/3.
  logic [NUM_CHANNELS-1:0] raw_vec;
  logic [NUM_CHANNELS-1:0] stable;
  logic [2:0]              water_pending;

  assign raw_vec = {raw_button_3, raw_button_2, raw_selector, raw_low_temperature,
                    raw_air_humidity, raw_earth_humidity, raw_high_water,
                    raw_mid_water, raw_low_water};

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q;
    logic [CW-1:0]          count_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: asynchronous active-low reset in the sensitivity list; state uses
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        sync_q   <= '0;
        stable_q <= 1'b0;
        count_q  <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_vec[i]};
        if (synced == stable_q) begin
          count_q <= '0;
        end else if (count_q == CNT_MAX) begin
          stable_q <= synced;
          count_q  <= '0;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end

    assign stable[i] = stable_q;

    if (i < 3) begin : g_water
      assign water_pending[i] = |count_q;
    end
  end

  // Water outputs move together, and only once no probe is mid-debounce.
  logic [2:0] water_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      water_q <= '0;
    end else if (!(|water_pending) && (stable[2:0] != water_q)) begin
      water_q <= stable[2:0];
    end
  end

  // Rising-edge detect on the debounced buttons, registered one cycle later.
  logic [1:0] btn_d;
  logic [1:0] pulse_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_d   <= '0;
      pulse_q <= '0;
    end else begin
      btn_d   <= stable[8:7];
      pulse_q <= stable[8:7] & ~btn_d;
    end
  end

  logic [6:0] levels;
  logic [6:0] levels_d;
  logic       change_q;

  assign levels = {stable[6:3], water_q};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      levels_d <= '0;
      change_q <= 1'b0;
    end else begin
      levels_d <= levels;
      change_q <= (levels != levels_d);
    end
  end

  assign low_water_level  = water_q[0];
  assign mid_water_level  = water_q[1];
  assign high_water_level = water_q[2];
  assign earth_humidity   = stable[3];
  assign air_humidity     = stable[4];
  assign low_temperature  = stable[5];
  assign selector         = stable[6];
  assign pulse_2          = pulse_q[0];
  assign pulse_3          = pulse_q[1];
  assign sensor_change    = change_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Edge 0 is the first rising edge that samples a newly applied raw value.
module tb_sensor_input_conditioner;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] raw = '0;
  logic [9:0] outs;

  logic low_water_level, mid_water_level, high_water_level;
  logic earth_humidity, air_humidity, low_temperature, selector;
  logic pulse_2, pulse_3, sensor_change;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sensor_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .raw_low_water      (raw[0]),
    .raw_mid_water      (raw[1]),
    .raw_high_water     (raw[2]),
    .raw_earth_humidity (raw[3]),
    .raw_air_humidity   (raw[4]),
    .raw_low_temperature(raw[5]),
    .raw_selector       (raw[6]),
    .raw_button_2       (raw[7]),
    .raw_button_3       (raw[8]),
    .low_water_level    (low_water_level),
    .mid_water_level    (mid_water_level),
    .high_water_level   (high_water_level),
    .earth_humidity     (earth_humidity),
    .air_humidity       (air_humidity),
    .low_temperature    (low_temperature),
    .selector           (selector),
    .pulse_2            (pulse_2),
    .pulse_3            (pulse_3),
    .sensor_change      (sensor_change)
  );

  // Output bits follow raw bit order, then pulse_2, pulse_3, sensor_change.
  assign outs = {sensor_change, pulse_3, pulse_2, selector, low_temperature,
                 air_humidity, earth_humidity, high_water_level,
                 mid_water_level, low_water_level};

  typedef struct {
    logic [8:0] raw;
    int         cycles;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  int pulses;
  int pulse_edge;
  int release_pulses;
  int pulse2_count;
  int change_count;
  logic [9:0] exp;

  initial begin
    // Air glitch rejection, then earth + low_temperature rising together.
    vecs[0]  = '{9'h010, 3, 10'h000};
    vecs[1]  = '{9'h000, 1, 10'h000};
    vecs[2]  = '{9'h010, 3, 10'h000};
    vecs[3]  = '{9'h000, 1, 10'h000};
    vecs[4]  = '{9'h010, 4, 10'h000};
    vecs[5]  = '{9'h010, 1, 10'h000};
    vecs[6]  = '{9'h010, 1, 10'h010};
    vecs[7]  = '{9'h010, 1, 10'h210};
    vecs[8]  = '{9'h010, 1, 10'h010};
    vecs[9]  = '{9'h038, 5, 10'h010};
    vecs[10] = '{9'h038, 1, 10'h038};
    vecs[11] = '{9'h038, 1, 10'h238};
    vecs[12] = '{9'h038, 1, 10'h038};

    // Reset state and asynchronous reset with all inputs high.
    repeat (2) step();
    check("reset_state", outs, 10'h000);
    reset_n = 1'b1;
    raw = '1;
    repeat (12) step();
    check("all_high_settled", outs, 10'h07F);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("async_reset", outs, 10'h000);
    #1;
    reset_n = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step();
      case (e)
        5:       exp = 10'h078;
        6:       exp = 10'h3FF;
        7:       exp = 10'h27F;
        8:       exp = 10'h07F;
        default: exp = 10'h000;
      endcase
      check($sformatf("post_reset_e%0d", e), outs, exp);
    end

    // Table-driven glitch and concurrent-change vectors.
    raw = '0;
    do_reset();
    check("table_start", outs, 10'h000);
    for (int i = 0; i < 13; i++) begin
      raw = vecs[i].raw;
      repeat (vecs[i].cycles) step();
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // Water group: low at edge 0, mid at edge 2, both commit at edge 8.
    raw = '0;
    do_reset();
    raw[0] = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      if (e == 2) raw[1] = 1'b1;
      step();
      exp = (e >= 8) ? 10'h003 : 10'h000;
      if (e == 9) exp = exp | 10'h200;
      check($sformatf("water_e%0d", e), outs, exp);
    end

    // Held button: one pulse at edge 6, nothing on release.
    raw = '0;
    do_reset();
    raw[8] = 1'b1;
    pulses = 0;
    pulse_edge = -1;
    release_pulses = 0;
    pulse2_count = 0;
    change_count = 0;
    for (int e = 0; e < 50; e++) begin
      step();
      if (pulse_3) begin
        pulses++;
        pulse_edge = e;
      end
      if (pulse_2) pulse2_count++;
      if (sensor_change) change_count++;
    end
    raw[8] = 1'b0;
    for (int e = 0; e < 30; e++) begin
      step();
      if (pulse_3) release_pulses++;
      if (sensor_change) change_count++;
    end
    check("btn3_pulse_count", pulses, 1);
    check("btn3_pulse_edge", pulse_edge, 6);
    check("btn3_release_pulses", release_pulses, 0);
    check("btn2_idle", pulse2_count, 0);
    check("btn_no_change_flag", change_count, 0);

    // Reset mid-debounce: selector rises at edge 5 after release.
    raw = '0;
    do_reset();
    raw[6] = 1'b1;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    check("sel_in_reset", selector, 1'b0);
    reset_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step();
      check($sformatf("sel_e%0d", e), selector, (e >= 5) ? 1'b1 : 1'b0);
    end
    check("sel_change_e6", sensor_change, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensor_input_conditioner.md
# sensor_input_conditioner

Front-end stage between the board pins and the irrigation top level. It synchronizes and debounces the raw water-level, humidity, temperature and selector inputs, and turns the two push-buttons into single-cycle pulses. Its outputs drive the `low/mid/high_water_level`, `earth_humidity`, `air_humidity`, `low_temperature`, `selector`, `pulse_2` and `pulse_3` inputs of the controller. The three water-level bits are committed together, so the controller's conflict checker never sees a transient mix of old and new levels.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth per input, minimum 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a change is accepted, minimum 2.
  - Counter width is clog2(DEBOUNCE_CYCLES).

Ports:
- `clock`: in, 1, the single system clock; all state changes on its rising edge.
- `reset_n`: in, 1, asynchronous, active-low reset.
- `raw_low_water`, `raw_mid_water`, `raw_high_water`: in, 1 each, water probes, active-high.
- `raw_earth_humidity`, `raw_air_humidity`, `raw_low_temperature`: in, 1 each, sensors.
- `raw_selector`: in, 1, mode switch.
- `raw_button_2`, `raw_button_3`: in, 1 each, push-buttons, active-high.
- `low_water_level`, `mid_water_level`, `high_water_level`: out, 1 each, committed water group.
- `earth_humidity`, `air_humidity`, `low_temperature`, `selector`: out, 1 each, debounced levels.
- `pulse_2`, `pulse_3`: out, 1 each, one-cycle pulse per debounced button press.
- `sensor_change`: out, 1, one-cycle flag when any level output changes value.

## Operation

- **Channels.** Nine identical channels, one per raw input. Each channel is a `SYNC_STAGES` synchronizer, then a debouncer holding a stable bit `s` and a counter `c`.
- **Debounce, per cycle:**
  - If synced input equals `s`: `c` ← 0.
  - Else if `c` == DEBOUNCE_CYCLES−1: `s` ← synced input, `c` ← 0.
  - Else: `c` ← `c`+1.
  - Any single-cycle glitch shorter than DEBOUNCE_CYCLES cycles is discarded and restarts the count.
- **Non-water levels.** `earth_humidity`, `air_humidity`, `low_temperature` and `selector` are the `s` registers, driven directly.
- **Water group commit.**
  - Output registers load all three water `s` bits in the same cycle.
  - They load only on a cycle where all three water counters are 0 (no pending change) and at least one `s` differs from its output.
  - While any water counter is non-zero, all three outputs hold.
- **Buttons.**
  - `pulse_n` is 1 for exactly one cycle, in the cycle after button `s` goes 0→1.
  - A 1→0 release produces nothing.
  - A held button produces one pulse only.
- **`sensor_change`.** 1 for one cycle, in the cycle after any of the seven level outputs changes. Several outputs changing together still give a single pulse.
- **Reset.**
  - `reset_n` low clears every synchronizer flop, `s`, counter and output to 0, immediately and independent of `clock`.
  - Mid-debounce progress is lost.
  - After release, an input already held high is a normal 0→1 change: it appears after the full latency, and buttons then emit one pulse.

## Timing

- **Level latency.** A raw change held stable is first sampled at edge 0. The matching `s`/level output changes at edge SYNC_STAGES+DEBOUNCE_CYCLES−1. This is 17 with defaults.
- **Water group latency.** Same as level latency, plus 1 cycle for the commit register. This is 18 with defaults.
  - When the three probes change at different times, the group commits one cycle after the last counter returns to 0.
- **Button latency.** Pulses appear one cycle after the corresponding `s` rise. This is 18 edges with defaults.
- **Flag latency.** `sensor_change` follows the level output by one cycle.
- **Simultaneous events.** Channels are fully independent apart from the water-group commit. No input blocks another.
- **Metastability.** Only the synchronizer outputs feed logic. Raw pins go to the first flop only.

## Test plan

All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.

1. **Reset.** Assert `reset_n`=0 mid-cycle with all raw inputs at 1 → every output reads 0 before the next edge. Release → `low_water_level`=1 at edge 6, `pulse_2` high only at edge 6, `sensor_change` high at edge 6.
2. **Glitch rejection.** Pulse `raw_air_humidity` high for 3 cycles, low for 1, high for 3 → `air_humidity` stays 0. Hold high for 4 → it rises at edge 5 after the hold starts.
3. **Water group atomicity.** `raw_low_water`↑ at cycle 0, `raw_mid_water`↑ at cycle 2 → all outputs stay 0 until both settle. Then `low` and `mid` rise in the same cycle (cycle 8), with a single `sensor_change`.
4. **Button hold.** `raw_button_3` high for 50 cycles, then low → exactly one `pulse_3` cycle (edge 6), and no pulse on release.
5. **Reset mid-debounce.** `raw_selector`↑, then `reset_n` low at cycle 3 for 1 cycle while the input stays high → `selector` rises 5 edges after `reset_n` release, not earlier.
6. **Concurrent changes.** `raw_earth_humidity`↑ and `raw_low_temperature`↑ on the same edge → both outputs rise on the same edge, with one `sensor_change` pulse.
